i2c_block_serializer: RTL and testbench
=======================================

I2C_BLOCK_SERIALIZER -- requirements
Module: i2c_block_serializer

Interface
REQ-001 The block SHALL have parameter NUM_BYTES, default 8, giving the number of bytes per block (block width = NUM_BYTES*8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port data_ready, input, 1 bit: one-cycle pulse; block_in holds a valid decrypted/encrypted block.
REQ-005 The block SHALL have port block_in, input, NUM_BYTES*8 bits: block from the output-byte stage (its to_i2c bus).
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous cancel from the I2C controller (STOP/NACK seen).
REQ-007 The block SHALL have port byte_req, input, 1 bit: one-cycle pulse from the I2C transmitter consuming the current tx_byte.
REQ-008 The block SHALL have port tx_byte, output, 8 bits: byte presented to the I2C transmitter (registered).
REQ-009 The block SHALL have port tx_valid, output, 1 bit: tx_byte is valid.
REQ-010 The block SHALL have port busy, output, 1 bit: a block is held and not yet fully sent.
REQ-011 The block SHALL have port block_done, output, 1 bit: one-cycle pulse after the last byte is consumed.
REQ-012 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a block is dropped.

Function
REQ-013 The block SHALL implement states IDLE and SEND; busy = tx_valid = (state == SEND).
REQ-014 In IDLE, data_ready SHALL capture block_in into a shift register, clear the byte count to 0, and enter SEND at that same edge.
REQ-015 Latency: tx_valid SHALL be high and tx_byte SHALL equal block_in[63:56] (MSB byte first) in the cycle after the data_ready edge.
REQ-016 In SEND, byte_req SHALL shift the register left by 8, increment the count, and present the next byte in the following cycle.
REQ-017 byte_req SHALL be ignored when tx_valid is 0.
REQ-018 When byte_req arrives with count == NUM_BYTES-1, the block SHALL pulse block_done for exactly one cycle and return to IDLE (tx_valid=0).
REQ-019 data_ready during SEND, other than on the final-byte cycle, SHALL be dropped, the held block SHALL be unaffected, and overrun SHALL pulse for one cycle.
REQ-020 data_ready coinciding with the final byte_req SHALL load the new block and remain in SEND with count 0: block_done pulses, overrun does not, and no idle cycle occurs.
REQ-021 abort SHALL force IDLE, clear the count and shift register, and suppress block_done; abort has priority over byte_req and data_ready in the same cycle.
REQ-022 The byte count SHALL be ceil(log2(NUM_BYTES)) bits wide and SHALL never exceed NUM_BYTES-1.

Reset
REQ-023 While n_rst = 0, the block SHALL be in IDLE with a zeroed shift register, count = 0, tx_byte = 8'h00, and tx_valid, busy, block_done and overrun all 0.
REQ-024 Reset asserted mid-block SHALL discard the block, with no block_done or overrun pulse after release.
REQ-025 The first data_ready SHALL be honoured on the first rising edge after n_rst deasserts.

Structure
REQ-026 The state enum (IDLE, SEND) SHALL live in the shared I2C/DES package i2c_des_pkg, alongside the BYTE_W = 8 constant.
REQ-027 The byte count SHALL be a single sub-module, byte_counter: clear, count_enable, rollover value NUM_BYTES-1, and a rollover_flag output.
REQ-028 All outputs SHALL be driven from flops; there SHALL be no combinational path from any input to any output.

Verification
REQ-029 The bench SHALL cover: block_in = 64'h1234567890abcdef, data_ready pulse, then byte_req every 3 cycles -> tx_byte sequence 12,34,56,78,90,ab,cd,ef, then one block_done pulse and busy=0.
REQ-030 The bench SHALL cover: data_ready while 3 bytes are still unsent -> one overrun pulse, and the remaining bytes of the original block are unchanged.
REQ-031 The bench SHALL cover: data_ready with block 64'hfedcba0987654321 on the 8th byte_req -> block_done pulse, no overrun, tx_byte = fe the next cycle, tx_valid stays 1.
REQ-032 The bench SHALL cover: abort after 4 bytes, together with byte_req -> IDLE next cycle, tx_valid=0, no block_done.
REQ-033 The bench SHALL cover: n_rst pulled low after 2 bytes -> all outputs 0 immediately (asynchronously), and stay 0 after release until the next data_ready.
REQ-034 The bench SHALL cover: byte_req pulses in IDLE -> no change to any output.

Source files
------------

// File: rtl/i2c_des_pkg.sv
// Shared I2C/DES definitions: byte width and the serializer state encoding.
package i2c_des_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage : i2c_des_pkg

// File: rtl/byte_counter.sv
// Byte position counter for the block serializer.
// Ports:
//   clk, n_rst     - clock, async active-low reset
//   clear          - synchronous clear to 0 (wins over count_enable)
//   count_enable   - advance by one; wraps to 0 after ROLLOVER
//   rollover_flag  - count currently equals ROLLOVER (last byte in flight)
module byte_counter #(
    parameter int unsigned ROLLOVER = 7,
    parameter int unsigned CNT_W    = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic count_enable,
    output logic rollover_flag
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear first, then increment with wrap at ROLLOVER.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == CNT_W'(ROLLOVER)) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign rollover_flag = (count_q == CNT_W'(ROLLOVER));

endmodule : byte_counter

// File: rtl/i2c_block_serializer.sv
// Holds one cipher block and hands it to the I2C transmitter MSB byte first.
// Ports:
//   clk, n_rst  - clock, async active-low reset
//   data_ready  - pulse: block_in valid this cycle
//   block_in    - NUM_BYTES*8-bit block to send
//   abort       - synchronous cancel (STOP/NACK), highest priority
//   byte_req    - pulse: transmitter consumed tx_byte
//   tx_byte     - current byte (flop-driven)
//   tx_valid    - tx_byte valid
//   busy        - a block is held and not fully sent
//   block_done  - pulse after the last byte is consumed
//   overrun     - pulse when an incoming block is dropped
module i2c_block_serializer
    import i2c_des_pkg::*;
#(
    parameter int unsigned NUM_BYTES = 8
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        data_ready,
    input  logic [NUM_BYTES*BYTE_W-1:0] block_in,
    input  logic                        abort,
    input  logic                        byte_req,
    output logic [BYTE_W-1:0]           tx_byte,
    output logic                        tx_valid,
    output logic                        busy,
    output logic                        block_done,
    output logic                        overrun
);

    localparam int unsigned BLK_W = NUM_BYTES * BYTE_W;
    localparam int unsigned CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    ser_state_e         state_q;
    logic [BLK_W-1:0]   shift_q;
    logic               valid_q;
    logic               done_q;
    logic               ovr_q;

    logic               last_flag;
    logic               req_v;
    logic               last_req;
    logic               cnt_clear;

    // Counter control: restart on abort, on any block load, and after the last byte.
    always_comb begin
        req_v     = byte_req & valid_q;
        last_req  = req_v & last_flag;
        cnt_clear = abort | ((state_q == IDLE) & data_ready) | last_req;
    end

    byte_counter #(
        .ROLLOVER (NUM_BYTES - 1),
        .CNT_W    (CNT_W)
    ) u_byte_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear),
        .count_enable  (req_v),
        .rollover_flag (last_flag)
    );

    // Serializer FSM with registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                shift_q <= '0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (data_ready) begin
                            shift_q <= block_in;
                            state_q <= SEND;
                            valid_q <= 1'b1;
                        end
                    end
                    SEND: begin
                        if (byte_req && last_flag) begin
                            done_q <= 1'b1;
                            // A block arriving with the final request chains without a gap.
                            if (data_ready) begin
                                shift_q <= block_in;
                            end else begin
                                shift_q <= shift_q << BYTE_W;
                                state_q <= IDLE;
                                valid_q <= 1'b0;
                            end
                        end else begin
                            if (byte_req) begin
                                shift_q <= shift_q << BYTE_W;
                            end
                            if (data_ready) begin
                                ovr_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_byte    = shift_q[BLK_W-1 -: BYTE_W];
    assign tx_valid   = valid_q;
    assign busy       = valid_q;
    assign block_done = done_q;
    assign overrun    = ovr_q;

endmodule : i2c_block_serializer

// File: tb/tb_i2c_block_serializer.sv
// Directed bench for i2c_block_serializer: vector table plus corner sequences.
module tb_i2c_block_serializer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        data_ready = 1'b0;
    logic [63:0] block_in = '0;
    logic        abort = 1'b0;
    logic        byte_req = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        busy;
    logic        block_done;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] BLK_A = 64'h1234567890abcdef;
    localparam logic [63:0] BLK_B = 64'hfedcba0987654321;

    typedef struct {
        logic        dr;
        logic [63:0] blk;
        logic        ab;
        logic        br;
        logic [7:0]  e_byte;
        logic        e_valid;
        logic        e_done;
        logic        e_ovr;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    i2c_block_serializer #(.NUM_BYTES(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .data_ready (data_ready),
        .block_in   (block_in),
        .abort      (abort),
        .byte_req   (byte_req),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .busy       (busy),
        .block_done (block_done),
        .overrun    (overrun)
    );

    task automatic check(input string name, input logic [7:0] eb, input logic ev,
                         input logic ed, input logic eo);
        n_checks++;
        if (tx_byte !== eb || tx_valid !== ev || busy !== ev ||
            block_done !== ed || overrun !== eo) begin
            n_fail++;
            $display("FAIL %s: got byte=%h valid=%b busy=%b done=%b ovr=%b, want byte=%h valid=%b busy=%b done=%b ovr=%b",
                     name, tx_byte, tx_valid, busy, block_done, overrun, eb, ev, ev, ed, eo);
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge), then check.
    task automatic step(input string name, input logic dr, input logic [63:0] blk,
                        input logic ab, input logic br, input logic [7:0] eb,
                        input logic ev, input logic ed, input logic eo);
        data_ready = dr;
        block_in   = blk;
        abort      = ab;
        byte_req   = br;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        abort      = 1'b0;
        byte_req   = 1'b0;
        check(name, eb, ev, ed, eo);
    endtask

    task automatic load_and_send(input logic [63:0] blk, input int nreq);
        logic [63:0] b;
        b = blk;
        step("load", 1'b1, blk, 1'b0, 1'b0, b[63:56], 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= nreq; i++) begin
            b = b << 8;
            step("req", 1'b0, '0, 1'b0, 1'b1, b[63:56], 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] a_bytes [8];
        a_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'hab, 8'hcd, 8'hef};

        // Vector table: byte_req in IDLE, then full block with byte_req every 3 cycles.
        vq.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, BLK_A, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0});
        for (int k = 0; k < 8; k++) begin
            vq.push_back('{1'b0, 64'h0, 1'b0, 1'b0, a_bytes[k], 1'b1, 1'b0, 1'b0});
            vq.push_back('{1'b0, 64'h0, 1'b0, 1'b0, a_bytes[k], 1'b1, 1'b0, 1'b0});
            if (k < 7)
                vq.push_back('{1'b0, 64'h0, 1'b0, 1'b1, a_bytes[k+1], 1'b1, 1'b0, 1'b0});
            else
                vq.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0});
        end
        vq.push_back('{1'b0, 64'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 64'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});

        // Reset state while n_rst is low.
        #12;
        check("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("after_release", 8'h00, 1'b0, 1'b0, 1'b0);

        foreach (vq[i]) begin
            step($sformatf("vec%0d", i), vq[i].dr, vq[i].blk, vq[i].ab, vq[i].br,
                 vq[i].e_byte, vq[i].e_valid, vq[i].e_done, vq[i].e_ovr);
        end

        // Overrun with 3 bytes unsent: held block untouched.
        load_and_send(BLK_A, 5);
        step("ovr_pulse", 1'b1, BLK_B, 1'b0, 1'b0, 8'hab, 1'b1, 1'b0, 1'b1);
        step("ovr_clear", 1'b0, '0, 1'b0, 1'b0, 8'hab, 1'b1, 1'b0, 1'b0);
        step("ovr_b6", 1'b0, '0, 1'b0, 1'b1, 8'hcd, 1'b1, 1'b0, 1'b0);
        step("ovr_b7", 1'b0, '0, 1'b0, 1'b1, 8'hef, 1'b1, 1'b0, 1'b0);
        step("ovr_done", 1'b0, '0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

        // Back-to-back chain on the final byte_req, then abort with byte_req after 4 bytes.
        load_and_send(BLK_A, 7);
        step("chain_load", 1'b1, BLK_B, 1'b0, 1'b1, 8'hfe, 1'b1, 1'b1, 1'b0);
        step("chain_hold", 1'b0, '0, 1'b0, 1'b0, 8'hfe, 1'b1, 1'b0, 1'b0);
        step("chain_b1", 1'b0, '0, 1'b0, 1'b1, 8'hdc, 1'b1, 1'b0, 1'b0);
        step("chain_b2", 1'b0, '0, 1'b0, 1'b1, 8'hba, 1'b1, 1'b0, 1'b0);
        step("chain_b3", 1'b0, '0, 1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0);
        step("chain_b4", 1'b0, '0, 1'b0, 1'b1, 8'h87, 1'b1, 1'b0, 1'b0);
        step("abort_req", 1'b0, '0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step("abort_idle", 1'b0, '0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // Abort beats data_ready in IDLE.
        step("abort_vs_dr", 1'b1, BLK_A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Abort on the last byte suppresses block_done; count restarts for the next block.
        load_and_send(BLK_B, 7);
        step("abort_last", 1'b0, '0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        load_and_send(BLK_A, 7);
        step("recount_done", 1'b0, '0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-block.
        load_and_send(BLK_A, 2);
        n_rst = 1'b0;
        #1;
        check("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        check("rst_held", 8'h00, 1'b0, 1'b0, 1'b0);
        step("rst_rel1", 1'b0, '0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        step("rst_rel2", 1'b0, '0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step("post_rst_load", 1'b1, BLK_B, 1'b0, 1'b0, 8'hfe, 1'b1, 1'b0, 1'b0);

        // First data_ready right after release is honoured.
        n_rst = 1'b0;
        #2;
        n_rst = 1'b1;
        step("first_edge_load", 1'b1, BLK_A, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_i2c_block_serializer
